// File: rtl/wresp_chan_mngr.sv
// Manager-side write response (B) channel controller.
// Keeps an in-order queue of issued write IDs, drives bready while responses
// are pending, and checks each response against the oldest outstanding ID.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no writes outstanding, bready low
// WAIT  | one or more writes outstanding, bready high
// ERR   | sticky error latched, bready low, issued IDs ignored until err_clr
// (2'b10 is unused and falls back to IDLE)
module wresp_chan_mngr #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bvalid,
  output logic             bready,
  input  logic [3:0]       bid,
  input  logic             bcomp,
  input  logic             reqc_m_valid,
  input  logic [3:0]       reqc_m_id,
  input  logic             err_clr,
  output logic             wr_stall,
  output logic [PTR_W:0]   outstanding,
  output logic             finish_mwr,
  output logic [3:0]       finish_mwr_id,
  output logic             resp_err,
  output logic [1:0]       err_code
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_ERR  = 2'b11
  } state_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             finish_q, finish_d;
  logic [3:0]       finish_id_q, finish_id_d;
  logic             resp_err_q, resp_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [3:0]       mem_q [DEPTH];

  logic [3:0] head;
  logic       active, hs, id_match, full;
  logic       ev_id, ev_comp, ev_ovf, any_err;
  logic       push, pop;

  // Event decode and next-state computation from registered state
  always_comb begin
    head     = mem_q[rd_ptr_q];
    active   = (state_q == S_IDLE) || (state_q == S_WAIT);
    hs       = bvalid & (state_q == S_WAIT);
    id_match = (bid == head);
    full     = (count_q == FULL_CNT);
    ev_id    = hs & ~id_match;
    ev_comp  = hs & id_match & ~bcomp;
    pop      = hs & id_match & bcomp;
    ev_ovf   = active & reqc_m_valid & full & ~pop;
    any_err  = ev_id | ev_comp | ev_ovf;
    // an erroring cycle discards the issued ID as well
    push     = active & reqc_m_valid & (~full | pop) & ~any_err;

    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    resp_err_d  = resp_err_q;
    err_code_d  = err_code_q;
    finish_d    = pop;
    finish_id_d = pop ? bid : finish_id_q;

    case (state_q)
      S_IDLE, S_WAIT: begin
        if (any_err) begin
          state_d    = S_ERR;
          resp_err_d = 1'b1;
          if (ev_id)        err_code_d = 2'b01;
          else if (ev_comp) err_code_d = 2'b10;
          else              err_code_d = 2'b11;
        end else begin
          if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
          if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
          else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
          state_d = (count_d != '0) ? S_WAIT : S_IDLE;
        end
      end
      S_ERR: begin
        if (err_clr) begin
          state_d    = S_IDLE;
          rd_ptr_d   = '0;
          wr_ptr_d   = '0;
          count_d    = '0;
          resp_err_d = 1'b0;
          err_code_d = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, pointers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      finish_q    <= 1'b0;
      finish_id_q <= 4'd0;
      resp_err_q  <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      finish_q    <= finish_d;
      finish_id_q <= finish_id_d;
      resp_err_q  <= resp_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // ID storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= reqc_m_id;
  end

  assign bready        = (state_q == S_WAIT);
  assign wr_stall      = (count_q == FULL_CNT) | (state_q == S_ERR);
  assign outstanding   = count_q;
  assign finish_mwr    = finish_q;
  assign finish_mwr_id = finish_id_q;
  assign resp_err      = resp_err_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_wresp_chan_mngr.sv
// Directed bench for wresp_chan_mngr with hand-computed expectations.
module tb_wresp_chan_mngr;

  logic       clk = 1'b0;
  logic       rst;
  logic       bvalid;
  logic       bready;
  logic [3:0] bid;
  logic       bcomp;
  logic       reqc_m_valid;
  logic [3:0] reqc_m_id;
  logic       err_clr;
  logic       wr_stall;
  logic [2:0] outstanding;
  logic       finish_mwr;
  logic [3:0] finish_mwr_id;
  logic       resp_err;
  logic [1:0] err_code;

  int total = 0;
  int bad   = 0;

  wresp_chan_mngr #(.DEPTH(4), .PTR_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .bvalid        (bvalid),
    .bready        (bready),
    .bid           (bid),
    .bcomp         (bcomp),
    .reqc_m_valid  (reqc_m_valid),
    .reqc_m_id     (reqc_m_id),
    .err_clr       (err_clr),
    .wr_stall      (wr_stall),
    .outstanding   (outstanding),
    .finish_mwr    (finish_mwr),
    .finish_mwr_id (finish_mwr_id),
    .resp_err      (resp_err),
    .err_code      (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs set before the call are sampled at this edge
  task automatic tick();
    @(posedge clk);
    #1;
    bvalid       = 1'b0;
    reqc_m_valid = 1'b0;
    err_clr      = 1'b0;
    rst          = 1'b0;
    bcomp        = 1'b1;
  endtask

  task automatic push(input logic [3:0] id);
    reqc_m_valid = 1'b1;
    reqc_m_id    = id;
    tick();
  endtask

  task automatic resp(input logic [3:0] id, input logic ok);
    bvalid = 1'b1;
    bid    = id;
    bcomp  = ok;
    tick();
  endtask

  task automatic clr();
    err_clr = 1'b1;
    tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".bready"}, 32'(bready), 0);
    chk({tag, ".stall"}, 32'(wr_stall), 0);
    chk({tag, ".outst"}, 32'(outstanding), 0);
    chk({tag, ".fin"}, 32'(finish_mwr), 0);
    chk({tag, ".finid"}, 32'(finish_mwr_id), 0);
    chk({tag, ".err"}, 32'(resp_err), 0);
    chk({tag, ".code"}, 32'(err_code), 0);
  endtask

  logic [3:0] ids [4];

  initial begin
    rst = 1'b1; bvalid = 0; bid = 0; bcomp = 1; reqc_m_valid = 0; reqc_m_id = 0; err_clr = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    chk_reset("rst");

    // single write/response
    push(4'd3);
    chk("t1.bready", 32'(bready), 1);
    chk("t1.outst", 32'(outstanding), 1);
    resp(4'd3, 1'b1);
    chk("t1.fin", 32'(finish_mwr), 1);
    chk("t1.finid", 32'(finish_mwr_id), 3);
    chk("t1.outst0", 32'(outstanding), 0);
    chk("t1.idle", 32'(bready), 0);
    tick();
    chk("t1.finone", 32'(finish_mwr), 0);
    chk("t1.idhold", 32'(finish_mwr_id), 3);

    // fill and drain back-to-back
    ids[0] = 4'd1; ids[1] = 4'd2; ids[2] = 4'd5; ids[3] = 4'd7;
    for (int i = 0; i < 4; i++) push(ids[i]);
    chk("t2.outst", 32'(outstanding), 4);
    chk("t2.stall", 32'(wr_stall), 1);
    for (int i = 0; i < 4; i++) begin
      resp(ids[i], 1'b1);
      chk($sformatf("t2.fin%0d", i), 32'(finish_mwr), 1);
      chk($sformatf("t2.id%0d", i), 32'(finish_mwr_id), 32'(ids[i]));
      chk($sformatf("t2.outst%0d", i), 32'(outstanding), 32'(3 - i));
      chk($sformatf("t2.stall%0d", i), 32'(wr_stall), 0);
    end
    chk("t2.idle", 32'(bready), 0);

    // push into a full queue alongside a pop, across the pointer wrap
    ids[0] = 4'd10; ids[1] = 4'd11; ids[2] = 4'd12; ids[3] = 4'd13;
    for (int i = 0; i < 4; i++) push(ids[i]);
    chk("t3.full", 32'(outstanding), 4);
    reqc_m_valid = 1'b1; reqc_m_id = 4'd9;
    resp(4'd10, 1'b1);
    chk("t3.fin", 32'(finish_mwr), 1);
    chk("t3.finid", 32'(finish_mwr_id), 10);
    chk("t3.outst", 32'(outstanding), 4);
    chk("t3.noerr", 32'(resp_err), 0);
    chk("t3.stall", 32'(wr_stall), 1);
    ids[0] = 4'd11; ids[1] = 4'd12; ids[2] = 4'd13; ids[3] = 4'd9;
    for (int i = 0; i < 4; i++) begin
      resp(ids[i], 1'b1);
      chk($sformatf("t3.id%0d", i), 32'(finish_mwr_id), 32'(ids[i]));
    end
    chk("t3.empty", 32'(outstanding), 0);

    // ID mismatch
    push(4'd4);
    push(4'd6);
    resp(4'd6, 1'b1);
    chk("t4.err", 32'(resp_err), 1);
    chk("t4.code", 32'(err_code), 1);
    chk("t4.bready", 32'(bready), 0);
    chk("t4.nofin", 32'(finish_mwr), 0);
    chk("t4.stall", 32'(wr_stall), 1);
    chk("t4.outst", 32'(outstanding), 2);
    push(4'd8);
    chk("t4.ignpush", 32'(outstanding), 2);
    chk("t4.sticky", 32'(err_code), 1);
    clr();
    chk("t4.clrout", 32'(outstanding), 0);
    chk("t4.clrerr", 32'(resp_err), 0);
    chk("t4.clrcode", 32'(err_code), 0);
    chk("t4.clrstall", 32'(wr_stall), 0);
    chk("t4.clrbready", 32'(bready), 0);

    // failed completion
    push(4'd2);
    resp(4'd2, 1'b0);
    chk("t5.code", 32'(err_code), 2);
    chk("t5.nofin", 32'(finish_mwr), 0);
    chk("t5.err", 32'(resp_err), 1);
    clr();

    // overflow
    for (int i = 0; i < 4; i++) push(4'(i));
    push(4'd5);
    chk("t5.ovf", 32'(err_code), 3);
    chk("t5.ovferr", 32'(resp_err), 1);
    chk("t5.ovfout", 32'(outstanding), 4);
    clr();

    // mismatch beats overflow when both happen together
    for (int i = 0; i < 4; i++) push(4'(i + 1));
    reqc_m_valid = 1'b1; reqc_m_id = 4'd15;
    resp(4'd14, 1'b1);
    chk("t5.prio", 32'(err_code), 1);
    chk("t5.priout", 32'(outstanding), 4);
    clr();

    // reset mid-operation
    push(4'd1); push(4'd2); push(4'd3);
    chk("t6.outst", 32'(outstanding), 3);
    rst = 1'b1;
    tick();
    chk_reset("t6");
    push(4'd0);
    chk("t6.bready", 32'(bready), 1);
    resp(4'd0, 1'b1);
    chk("t6.fin", 32'(finish_mwr), 1);
    chk("t6.finid", 32'(finish_mwr_id), 0);
    chk("t6.outst0", 32'(outstanding), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wresp_chan_mngr.md
# wresp_chan_mngr

Manager-side write response (B) channel controller for the tiny AXI-style bus. It records the ID of every write issued by the local write-request logic in an in-order outstanding queue and drives `bready` while responses are pending. Each accepted response is checked against the oldest outstanding ID and `bcomp`. The block reports completion, or a sticky error, to the manager's write logic, and it applies back-pressure when the queue is full.

## Interface
- `DEPTH`, 4: outstanding-write queue depth. Must be a power of 2, ≥2.
- `PTR_W`, 2: log2(DEPTH).
- `clk`  input  1  single clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `bvalid`  input  1  response valid from the subordinate.
- `bready`  output  1  response ready to the subordinate.
- `bid`  input  4  response ID.
- `bcomp`  input  1  1 = write completed OK; 0 = failed.
- `reqc_m_valid`  input  1  one-cycle pulse: a write request was issued.
- `reqc_m_id`  input  4  ID of the issued write.
- `err_clr`  input  1  clears the error state and flushes the queue.
- `wr_stall`  output  1  issue inhibit to the write-request logic.
- `outstanding`  output  PTR_W+1  number of queued IDs.
- `finish_mwr`  output  1  one-cycle pulse: a write finished OK.
- `finish_mwr_id`  output  4  ID of the finished write; holds until the next finish.
- `resp_err`  output  1  sticky error flag.
- `err_code`  output  2  01 = ID mismatch; 10 = `bcomp`=0; 11 = queue overflow; 00 = none.

## Operation
- Queue: a circular FIFO of `DEPTH` × 4-bit IDs with `PTR_W`-bit read/write pointers that wrap modulo `DEPTH`. The count is `PTR_W+1` bits and is driven onto `outstanding`.
- Push: on `reqc_m_valid`, when not full and not in ERR.
- Pop: on handshake (`bvalid & bready`) with `bid == head` and `bcomp == 1`.
- Push and pop in the same cycle: both pointers advance and the count is unchanged. This is legal when full: the pop frees the slot.
- State machine, 2-bit:
  - IDLE: count == 0. `bready` = 0.
  - WAIT: count > 0. `bready` = 1.
  - ERR: `bready` = 0; pushes are ignored.
- Transitions:
  - IDLE→WAIT when a push occurs.
  - WAIT→IDLE when a pop leaves the count at 0 with no simultaneous push.
  - IDLE/WAIT→ERR on any error event.
  - ERR→IDLE on `err_clr`: both pointers and the count are reset to 0.
  - `err_clr` outside ERR has no effect.
  - Encoding 2'b10 is unused and must recover to IDLE.
- Error events:
  - Handshake with `bid != head` → code 01.
  - Handshake with `bid == head` and `bcomp == 0` → code 10.
  - `reqc_m_valid` while full with no simultaneous pop → code 11; the pushed ID is dropped.
  - Priority when events coincide: 01 > 10 > 11.
  - An erroring handshake does not pop, and any simultaneous push is discarded.
- `resp_err` and `err_code` are set on entry to ERR, stay constant while in ERR, and clear together with the return to IDLE.
- `wr_stall` = (count == DEPTH) | (state == ERR), computed combinationally from registered state.
- `bready` is a decode of the registered state only. It has no combinational path from `bvalid`.

## Timing
- Reset values: `bready` 0, `wr_stall` 0, `outstanding` 0, `finish_mwr` 0, `finish_mwr_id` 0, `resp_err` 0, `err_code` 0, state IDLE, pointers 0.
- Reset mid-operation discards all queued IDs; the next cycle is IDLE.
- A push in cycle N makes `bready` = 1 from cycle N+1. A `bvalid` present in cycle N with an empty queue is not accepted until N+1.
- A successful handshake in cycle N gives `finish_mwr` = 1 and `finish_mwr_id` = `bid` in cycle N+1; `outstanding` decrements at N+1.
- Back-to-back responses: one per cycle while in WAIT, with one `finish_mwr` pulse each.
- An error handshake in cycle N gives state ERR, `resp_err` = 1 and `bready` = 0 in N+1. No `finish_mwr` is issued.
- `err_clr` in cycle N gives IDLE with `outstanding` = 0 and `wr_stall` = 0 in N+1.

## Test plan
- Reset, then push ID 3. In the next cycle drive `bvalid`=1, `bid`=3, `bcomp`=1 → `bready` is 1 from the cycle after the push; `finish_mwr` pulses once with `finish_mwr_id`=3; `outstanding` returns 0; state returns to IDLE.
- Push IDs 1, 2, 5, 7 → `outstanding`=4 and `wr_stall`=1. Then return B responses 1, 2, 5, 7 back-to-back → four consecutive `finish_mwr` pulses in order; `wr_stall` drops after the first pop.
- With the queue full, push ID 9 in the same cycle as an accepted response for the head → no error, `outstanding` stays 4, and ID 9 is later completed at its position after the wrap.
- Push IDs 4 and 6, then respond with `bid`=6 → `resp_err`=1, `err_code`=01, `bready`=0. Assert `err_clr` → IDLE, `outstanding`=0, `resp_err`=0.
- Push ID 2, then respond with `bid`=2, `bcomp`=0 → `err_code`=10 and no `finish_mwr`. Separately, fill the queue and push again with no pop → `err_code`=11.
- Assert `rst` with 3 IDs outstanding → all outputs at their reset values the next cycle. A subsequent push of ID 0 and a response complete normally.
